// File: rtl/arb_pkg.sv
// Shared types and the rotating-priority search for the 16-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Walk offsets from the far end back to zero so the nearest set bit at or after ptr wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req_vec,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    pick = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (req_vec[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/decoder_4_16.sv
// 4-to-16 one-hot decoder with an enable; all-zero output when disabled.
module decoder_4_16
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] dec_o
);

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_dec
      assign dec_o[gi] = en_i && (idx_i == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with a per-winner hold timeout.
// Grant is held until done, requester withdrawal, or MAX_HOLD cycles elapse.
module rr_arbiter_16
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic       HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;

  logic rel_done, rel_wd, rel_to;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign rel_done = done;
  assign rel_wd   = !req[gnt_idx_q];
  assign rel_to   = HOLD_EN && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          gnt_idx_d   = rr_pick(req, ptr_q);
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (rel_done || rel_wd || rel_to) begin
          // Winner drops to lowest priority for the next round.
          ptr_d       = gnt_idx_q + IDX_W'(1);
          gnt_valid_d = 1'b0;
          state_d     = IDLE;
          timeout_d   = rel_to && !rel_done && !rel_wd;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_idx   = gnt_idx_q;
    gnt_valid = gnt_valid_q;
    timeout   = timeout_q;
  end

  decoder_4_16 u_dec (
    .idx_i (gnt_idx_q),
    .en_i  (gnt_valid_q),
    .dec_o (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed-vector bench for rr_arbiter_16 with MAX_HOLD = 8.
module tb_rr_arbiter_16;

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic [15:0] exp_gnt;
    logic [3:0]  exp_idx;
    logic        exp_valid;
    logic        exp_to;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int errors;
  int checks;
  vec_t vecs[$];

  rr_arbiter_16 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] g, input logic [3:0] i,
                         input logic v, input logic t);
    chk({tag, ".gnt"}, gnt, g);
    chk({tag, ".gnt_idx"}, {12'h0, gnt_idx}, {12'h0, i});
    chk({tag, ".gnt_valid"}, {15'h0, gnt_valid}, {15'h0, v});
    chk({tag, ".timeout"}, {15'h0, timeout}, {15'h0, t});
  endtask

  task automatic add(input logic [15:0] r, input logic d, input logic [15:0] g,
                     input logic [3:0] i, input logic v, input logic t);
    vec_t e;
    e.req = r; e.done = d; e.exp_gnt = g; e.exp_idx = i; e.exp_valid = v; e.exp_to = t;
    vecs.push_back(e);
  endtask

  task automatic step(input logic [15:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;

    // Idle after reset
    for (int k = 0; k < 5; k++) add(16'h0000, 0, 16'h0000, 4'd0, 0, 0);
    // Two requesters, done after two grant cycles, one bubble, then next
    add(16'h0009, 0, 16'h0001, 4'd0, 1, 0);
    add(16'h0009, 0, 16'h0001, 4'd0, 1, 0);
    add(16'h0009, 1, 16'h0000, 4'd0, 0, 0);
    add(16'h0009, 0, 16'h0008, 4'd3, 1, 0);
    add(16'h0009, 1, 16'h0000, 4'd3, 0, 0);
    // Wrap-around: winner 14, then 15, then ptr wraps to 0 -> 1
    add(16'h4000, 0, 16'h4000, 4'd14, 1, 0);
    add(16'h4000, 1, 16'h0000, 4'd14, 0, 0);
    add(16'h8002, 0, 16'h8000, 4'd15, 1, 0);
    add(16'h8002, 1, 16'h0000, 4'd15, 0, 0);
    add(16'h8002, 0, 16'h0002, 4'd1, 1, 0);
    // Withdrawal releases without a timeout pulse; done in IDLE is ignored
    add(16'h0000, 0, 16'h0000, 4'd1, 0, 0);
    add(16'h0000, 1, 16'h0000, 4'd1, 0, 0);
    // Timeout: exactly 8 grant cycles, a one-cycle pulse, then re-grant
    for (int k = 0; k < 8; k++) add(16'h0010, 0, 16'h0010, 4'd4, 1, 0);
    add(16'h0010, 0, 16'h0000, 4'd4, 0, 1);
    // done coincides with the last hold cycle: no pulse
    for (int k = 0; k < 8; k++) add(16'h0010, 0, 16'h0010, 4'd4, 1, 0);
    add(16'h0010, 1, 16'h0000, 4'd4, 0, 0);
    // Other req bits ignored mid-grant; withdrawal with another requester pending
    add(16'h0020, 0, 16'h0020, 4'd5, 1, 0);
    add(16'h0021, 0, 16'h0020, 4'd5, 1, 0);
    add(16'h0001, 0, 16'h0000, 4'd5, 0, 0);
    add(16'h0001, 0, 16'h0001, 4'd0, 1, 0);
    add(16'h0003, 0, 16'h0001, 4'd0, 1, 0);
    add(16'h0003, 1, 16'h0000, 4'd0, 0, 0);
    add(16'h0003, 0, 16'h0002, 4'd1, 1, 0);
    add(16'h0003, 1, 16'h0000, 4'd1, 0, 0);
    add(16'h0003, 0, 16'h0001, 4'd0, 1, 0);
    add(16'h0000, 0, 16'h0000, 4'd0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all("reset", 16'h0000, 4'd0, 1'b0, 1'b0);

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].req, vecs[k].done);
      $display("vec %0d req=%h done=%b gnt=%h idx=%0d valid=%b to=%b",
               k, vecs[k].req, vecs[k].done, gnt, gnt_idx, gnt_valid, timeout);
      chk_all($sformatf("vec%0d", k), vecs[k].exp_gnt, vecs[k].exp_idx,
              vecs[k].exp_valid, vecs[k].exp_to);
    end

    // Async reset mid-grant: ptr is 1 here, so the lone request 10 wins
    step(16'h0400, 0);
    $display("seq grant_before_reset gnt=%h idx=%0d valid=%b", gnt, gnt_idx, gnt_valid);
    chk_all("pre_arst", 16'h0400, 4'd10, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    $display("seq async_reset gnt=%h idx=%0d valid=%b", gnt, gnt_idx, gnt_valid);
    chk_all("arst", 16'h0000, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(16'hFFFF, 0);
    $display("seq after_reset gnt=%h idx=%0d valid=%b", gnt, gnt_idx, gnt_valid);
    chk_all("post_arst", 16'h0001, 4'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
